// File: rtl/dm_run_control_if.sv
// Debug-module run-control bundle: host command handshake, core debug
// handshake and the run-state status flags. Signal names keep the
// module-side direction suffixes.
interface dm_run_control_if;
  logic       host_cmd_valid_i;
  logic [1:0] host_cmd_i;
  logic       host_cmd_ready_o;

  logic       dm_halt_req_o;
  logic       dm_step_req_o;
  logic       dm_halt_ack_i;
  logic       dm_resume_ack_i;
  logic       dm_ebreak_i;
  logic       dm_step_exec_i;

  logic       status_running_o;
  logic       status_halted_o;
  logic       status_busy_o;
  logic       status_resumeack_o;
  logic [1:0] status_cause_o;
  logic [1:0] status_err_o;

  // Host/core side: drives commands and acknowledges, observes requests and status.
  modport master (
    output host_cmd_valid_i, host_cmd_i,
    output dm_halt_ack_i, dm_resume_ack_i, dm_ebreak_i, dm_step_exec_i,
    input  host_cmd_ready_o, dm_halt_req_o, dm_step_req_o,
    input  status_running_o, status_halted_o, status_busy_o,
    input  status_resumeack_o, status_cause_o, status_err_o
  );

  // Run-control block side.
  modport slave (
    input  host_cmd_valid_i, host_cmd_i,
    input  dm_halt_ack_i, dm_resume_ack_i, dm_ebreak_i, dm_step_exec_i,
    output host_cmd_ready_o, dm_halt_req_o, dm_step_req_o,
    output status_running_o, status_halted_o, status_busy_o,
    output status_resumeack_o, status_cause_o, status_err_o
  );
endinterface

// File: rtl/dm_run_control.sv
// Debug-module run control: sequences halt / resume / single-step handshakes
// with the core, bounds every handshake with an acknowledge timeout and keeps
// sticky status (halt cause, resume-ack, first error). Every output is a flop
// loaded from the decode of the next state, so no input reaches an output
// combinationally.
module dm_run_control #(
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input logic              clk_i,
  input logic              reset_i,
  dm_run_control_if.slave  bus
);

  localparam int unsigned    CNT_W    = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [1:0] CMD_HALT   = 2'b00;
  localparam logic [1:0] CMD_RESUME = 2'b01;
  localparam logic [1:0] CMD_STEP   = 2'b10;
  localparam logic [1:0] CMD_CLR    = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_HALTREQ = 2'b01;
  localparam logic [1:0] CAUSE_STEP    = 2'b10;
  localparam logic [1:0] CAUSE_EBREAK  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    ST_RUNNING    = 3'd0,
    ST_HALT_REQ   = 3'd1,
    ST_HALTED     = 3'd2,
    ST_RESUME_REQ = 3'd3,
    ST_STEP_REQ   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       err_q, err_d;
  logic             resumeack_q, resumeack_d;
  logic             step_flag_q, step_flag_d;
  logic             ready_q, ready_d;
  logic             halt_req_q, halt_req_d;
  logic             step_req_q, step_req_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             busy_q, busy_d;

  logic             cmd_acc_s;
  logic             timeout_s;
  logic             step_done_s;
  logic             in_wait_s;

  // ready_q already encodes "state is RUNNING or HALTED"
  assign cmd_acc_s   = bus.host_cmd_valid_i & ready_q;
  assign timeout_s   = (cnt_q == CNT_LAST);
  assign step_done_s = bus.dm_halt_ack_i & (step_flag_q | bus.dm_step_exec_i);
  assign in_wait_s   = (state_q == ST_HALT_REQ) || (state_q == ST_RESUME_REQ) ||
                       (state_q == ST_STEP_REQ);

  // State, sticky status and registered outputs; reset aborts any handshake.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_RUNNING;
      cnt_q       <= CNT_ZERO;
      cause_q     <= CAUSE_NONE;
      pend_q      <= CAUSE_NONE;
      err_q       <= ERR_NONE;
      resumeack_q <= 1'b0;
      step_flag_q <= 1'b0;
      ready_q     <= 1'b1;
      halt_req_q  <= 1'b0;
      step_req_q  <= 1'b0;
      running_q   <= 1'b1;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      resumeack_q <= resumeack_d;
      step_flag_q <= step_flag_d;
      ready_q     <= ready_d;
      halt_req_q  <= halt_req_d;
      step_req_q  <= step_req_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: ebreak beats a same-cycle HALT, an ack beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUNNING: begin
        if (bus.dm_ebreak_i) begin
          state_d = ST_HALT_REQ;
        end else if (cmd_acc_s && (bus.host_cmd_i == CMD_HALT)) begin
          state_d = ST_HALT_REQ;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      ST_HALT_REQ: begin
        if (bus.dm_halt_ack_i) begin
          state_d = ST_HALTED;
        end else if (timeout_s) begin
          state_d = ST_RUNNING;
        end else begin
          state_d = ST_HALT_REQ;
        end
      end
      ST_HALTED: begin
        if (cmd_acc_s && (bus.host_cmd_i == CMD_RESUME)) begin
          state_d = ST_RESUME_REQ;
        end else if (cmd_acc_s && (bus.host_cmd_i == CMD_STEP)) begin
          state_d = ST_STEP_REQ;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RESUME_REQ: begin
        if (bus.dm_resume_ack_i) begin
          state_d = ST_RUNNING;
        end else if (timeout_s) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RESUME_REQ;
        end
      end
      ST_STEP_REQ: begin
        if (step_done_s) begin
          state_d = ST_HALTED;
        end else if (timeout_s) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_STEP_REQ;
        end
      end
      default: state_d = ST_RUNNING;
    endcase
  end

  // Wait counter, halt cause, sticky error / resume-ack and step-executed flag.
  always_comb begin
    cnt_d       = CNT_ZERO;
    cause_d     = cause_q;
    pend_d      = pend_q;
    err_d       = err_q;
    resumeack_d = resumeack_q;
    step_flag_d = step_flag_q;

    // Counts only while staying in a wait state; any entry starts from zero.
    if (in_wait_s && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end

    case (state_q)
      ST_RUNNING: begin
        if (bus.dm_ebreak_i) begin
          pend_d = CAUSE_EBREAK;
        end else if (cmd_acc_s && (bus.host_cmd_i == CMD_HALT)) begin
          pend_d = CAUSE_HALTREQ;
        end else begin
          pend_d = pend_q;
        end
        if (cmd_acc_s) begin
          case (bus.host_cmd_i)
            CMD_RESUME, CMD_STEP: begin
              resumeack_d = 1'b0;
              if (err_q == ERR_NONE) begin
                err_d = ERR_ILLEGAL;
              end else begin
                err_d = err_q;
              end
            end
            CMD_CLR: begin
              err_d       = ERR_NONE;
              resumeack_d = 1'b0;
            end
            default: begin
              err_d       = err_q;
              resumeack_d = resumeack_q;
            end
          endcase
        end else begin
          err_d = err_q;
        end
      end
      ST_HALT_REQ: begin
        if (bus.dm_halt_ack_i) begin
          cause_d = pend_q;
        end else if (timeout_s && (err_q == ERR_NONE)) begin
          err_d = ERR_TIMEOUT;
        end else begin
          cause_d = cause_q;
        end
      end
      ST_HALTED: begin
        if (cmd_acc_s) begin
          case (bus.host_cmd_i)
            CMD_RESUME: resumeack_d = 1'b0;
            CMD_STEP: begin
              resumeack_d = 1'b0;
              step_flag_d = 1'b0;
            end
            CMD_CLR: begin
              err_d       = ERR_NONE;
              resumeack_d = 1'b0;
            end
            default: resumeack_d = resumeack_q;
          endcase
        end else begin
          resumeack_d = resumeack_q;
        end
      end
      ST_RESUME_REQ: begin
        if (bus.dm_resume_ack_i) begin
          resumeack_d = 1'b1;
          cause_d     = CAUSE_NONE;
        end else if (timeout_s && (err_q == ERR_NONE)) begin
          err_d = ERR_TIMEOUT;
        end else begin
          resumeack_d = resumeack_q;
        end
      end
      ST_STEP_REQ: begin
        if (step_done_s) begin
          cause_d     = CAUSE_STEP;
          step_flag_d = 1'b0;
        end else if (timeout_s) begin
          step_flag_d = 1'b0;
          if (err_q == ERR_NONE) begin
            err_d = ERR_TIMEOUT;
          end else begin
            err_d = err_q;
          end
        end else if (bus.dm_step_exec_i) begin
          step_flag_d = 1'b1;
        end else begin
          step_flag_d = step_flag_q;
        end
      end
      default: begin
        step_flag_d = 1'b0;
        pend_d      = CAUSE_NONE;
      end
    endcase
  end

  // Output decode of the next state, loaded into the output flops.
  always_comb begin
    ready_d    = 1'b0;
    halt_req_d = 1'b0;
    step_req_d = 1'b0;
    running_d  = 1'b0;
    halted_d   = 1'b0;
    busy_d     = 1'b0;
    case (state_d)
      ST_RUNNING: begin
        ready_d   = 1'b1;
        running_d = 1'b1;
      end
      ST_HALT_REQ: begin
        halt_req_d = 1'b1;
        busy_d     = 1'b1;
      end
      ST_HALTED: begin
        ready_d    = 1'b1;
        halt_req_d = 1'b1;
        halted_d   = 1'b1;
      end
      ST_RESUME_REQ: begin
        busy_d = 1'b1;
      end
      ST_STEP_REQ: begin
        halt_req_d = 1'b1;
        step_req_d = 1'b1;
        busy_d     = 1'b1;
      end
      default: begin
        ready_d   = 1'b1;
        running_d = 1'b1;
      end
    endcase
  end

  assign bus.host_cmd_ready_o   = ready_q;
  assign bus.dm_halt_req_o      = halt_req_q;
  assign bus.dm_step_req_o      = step_req_q;
  assign bus.status_running_o   = running_q;
  assign bus.status_halted_o    = halted_q;
  assign bus.status_busy_o      = busy_q;
  assign bus.status_resumeack_o = resumeack_q;
  assign bus.status_cause_o     = cause_q;
  assign bus.status_err_o       = err_q;

endmodule

// File: doc/dm_run_control.md
DM_RUN_CONTROL -- requirements
Module: dm_run_control

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 1024; maximum cycles to wait for any core acknowledge.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-low reset.
REQ-004 host_cmd_valid_i  input  1  host command strobe.
REQ-005 host_cmd_i  input  2  command: 00 HALT, 01 RESUME, 10 STEP, 11 CLR.
REQ-006 host_cmd_ready_o  output  1  command accepted when valid & ready.
REQ-007 dm_halt_req_o  output  1  halt request to core debug-support FSM.
REQ-008 dm_step_req_o  output  1  request to set dcsr.step in debug CSRs.
REQ-009 dm_halt_ack_i  input  1  core halt acknowledge.
REQ-010 dm_resume_ack_i  input  1  core resume acknowledge.
REQ-011 dm_ebreak_i  input  1  core hit software breakpoint.
REQ-012 dm_step_exec_i  input  1  core executing single step.
REQ-013 status_running_o / status_halted_o / status_busy_o  output  1 each  run-state flags.
REQ-014 status_resumeack_o  output  1  sticky resume-acknowledged flag.
REQ-015 status_cause_o  output  2  halt cause: 00 none, 01 haltreq, 10 step, 11 ebreak.
REQ-016 status_err_o  output  2  sticky error: 00 none, 01 timeout, 10 illegal command.

Function
REQ-017 FSM states SHALL be RUNNING, HALT_REQ, HALTED, RESUME_REQ, STEP_REQ.
REQ-018 host_cmd_ready_o SHALL be 1 only in RUNNING or HALTED.
REQ-019 RUNNING: dm_halt_req_o=0; accepted HALT -> HALT_REQ, pending cause 01; dm_ebreak_i=1 -> HALT_REQ, pending cause 11.
REQ-020 Same-cycle HALT command and dm_ebreak_i in RUNNING SHALL give cause 11.
REQ-021 HALT_REQ: dm_halt_req_o=1; dm_halt_ack_i -> HALTED, status_cause_o loaded with pending cause.
REQ-022 HALTED: dm_halt_req_o=1; RESUME -> RESUME_REQ; STEP -> STEP_REQ; HALT ignored, no error.
REQ-023 RESUME_REQ: dm_halt_req_o=0; dm_resume_ack_i -> RUNNING, status_resumeack_o set, status_cause_o cleared to 00.
REQ-024 STEP_REQ: dm_halt_req_o=1, dm_step_req_o=1; latch flag on dm_step_exec_i=1; dm_halt_ack_i with flag set (or dm_step_exec_i=1 same cycle) -> HALTED, cause 10.
REQ-025 dm_step_req_o SHALL be 0 in all states except STEP_REQ.
REQ-026 Accepting RESUME or STEP SHALL clear status_resumeack_o the same edge.
REQ-027 RESUME or STEP accepted in RUNNING SHALL set status_err_o=10, no state change.
REQ-028 CLR SHALL clear status_err_o and status_resumeack_o in either accepting state; no state change.
REQ-029 Wait counter SHALL clear on entry to HALT_REQ/RESUME_REQ/STEP_REQ, increment each cycle there.
REQ-030 Counter reaching ACK_TIMEOUT-1 without ack: HALT_REQ -> RUNNING; RESUME_REQ -> HALTED; STEP_REQ -> HALTED; status_err_o=01 in each case.
REQ-031 Ack in same cycle as timeout expiry SHALL win; no error.
REQ-032 Error code SHALL hold first error until CLR; later errors ignored.
REQ-033 status_busy_o SHALL be 1 in HALT_REQ, RESUME_REQ, STEP_REQ.
REQ-034 Counter width SHALL be $clog2(ACK_TIMEOUT)+1; no wrap possible.
REQ-035 Unreachable state encodings SHALL recover to RUNNING next cycle.

Reset
REQ-036 On reset_i=0: state RUNNING, dm_halt_req_o=0, dm_step_req_o=0, counter 0, cause 00, err 00, resumeack 0, step flag 0.
REQ-037 Reset asserted mid-handshake SHALL abort it immediately; no ack is remembered.
REQ-038 All outputs SHALL be registered state decode; no input-to-output combinational path except host_cmd_ready_o (state only).

Verification
REQ-039 Reset, HALT cmd, halt_ack 3 cycles later -> halt_req=1 from next edge, halted=1, cause=01, busy high 3 cycles.
REQ-040 From HALTED, RESUME, resume_ack after 2 cycles -> halt_req=0, running=1, resumeack=1, cause=00.
REQ-041 From HALTED, STEP, step_exec 1 cycle then halt_ack -> step_req=1 during STEP_REQ, halted=1, cause=10, step_req=0.
REQ-042 RUNNING, dm_ebreak_i pulse with simultaneous HALT cmd -> HALT_REQ, after ack cause=11.
REQ-043 ACK_TIMEOUT=8, HALT with no ack -> after 8 cycles running=1, halt_req=0, err=01; RESUME in RUNNING keeps err=01; CLR -> err=00.
REQ-044 Reset pulsed during RESUME_REQ -> all outputs at REQ-036 values; late resume_ack ignored.
